// File: rtl/instruction_fetch_queue_if.sv
// Handshake bundle between the fetch queue and its neighbours: PC source,
// instruction memory and decode.
interface instruction_fetch_queue_if;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_misaligned;
  logic        flush;
  logic        busy;

  modport slave (
    input  pc_in, pc_valid, imem_req_ready, imem_resp_valid, imem_resp_data,
           instr_ready, flush,
    output pc_ready, imem_req_valid, imem_req_addr, instr_valid, instr_data,
           instr_pc, instr_misaligned, busy
  );

  modport master (
    output pc_in, pc_valid, imem_req_ready, imem_resp_valid, imem_resp_data,
           instr_ready, flush,
    input  pc_ready, imem_req_valid, imem_req_addr, instr_valid, instr_data,
           instr_pc, instr_misaligned, busy
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// In-order instruction fetch queue: accepts PCs, issues word reads, matches
// in-order responses to entries and drains late responses after a flush.
module instruction_fetch_queue #(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  instruction_fetch_queue_if.slave io
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_I = (CW+1)'(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef struct packed {
    logic        alloc;
    logic        filled;
    logic [31:0] pc;
    logic [31:0] data;
    logic        misaligned;
  } entry_t;

  entry_t [DEPTH-1:0] ent_q, ent_d;
  ptr_t               head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CW-1:0]      drop_q, drop_d;
  logic [CW-1:0]      used, unfilled;
  logic [CW:0]        inflight;
  logic               space, mis, accept, pop;
  ptr_t               scan_idx;
  logic               scan_hit;

  always_comb begin
    used     = '0;
    unfilled = '0;
    for (int i = 0; i < DEPTH; i++) begin
      used     = used + CW'(ent_q[i].alloc);
      unfilled = unfilled + CW'(ent_q[i].alloc & ~ent_q[i].filled);
    end
  end

  // Late responses still owed to memory count against the issue budget.
  assign inflight = {1'b0, unfilled} + {1'b0, drop_q};
  assign space    = (used < DEPTH_C) && (inflight < DEPTH_I);
  assign mis      = io.pc_in[1:0] != 2'b00;

  assign io.imem_req_valid = io.pc_valid & ~mis & space & ~io.flush;
  assign io.imem_req_addr  = io.pc_in;
  assign io.pc_ready       = space & ~io.flush & (mis | io.imem_req_ready);
  assign accept            = io.pc_valid & io.pc_ready;

  assign io.instr_valid      = ent_q[head_q].alloc & ent_q[head_q].filled;
  assign io.instr_data       = ent_q[head_q].data;
  assign io.instr_pc         = ent_q[head_q].pc;
  assign io.instr_misaligned = ent_q[head_q].misaligned;
  assign io.busy             = (used != '0) | (drop_q != '0);
  assign pop                 = io.instr_valid & io.instr_ready & ~io.flush;

  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    drop_d = drop_q;
    if (io.flush) begin
      ent_d  = '0;
      head_d = '0;
      tail_d = '0;
      drop_d = drop_q + unfilled;
      if (io.imem_resp_valid && drop_d != '0) drop_d = drop_d - CW'(1);
    end else begin
      if (pop) begin
        ent_d[head_q].alloc  = 1'b0;
        ent_d[head_q].filled = 1'b0;
        head_d = head_q + ptr_t'(1);
      end
      if (accept) begin
        ent_d[tail_q].alloc      = 1'b1;
        ent_d[tail_q].filled     = mis;
        ent_d[tail_q].pc         = io.pc_in;
        ent_d[tail_q].data       = '0;
        ent_d[tail_q].misaligned = mis;
        tail_d = tail_q + ptr_t'(1);
      end
      if (io.imem_resp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else if (unfilled != '0) begin
          ent_d[fill_q].filled = 1'b1;
          ent_d[fill_q].data   = io.imem_resp_data;
        end
      end
    end
    // fill tracks the oldest unfilled entry (tail when none), so misaligned
    // entries and wrap-around never leave it pointing at a younger entry.
    fill_d   = tail_d;
    scan_hit = 1'b0;
    scan_idx = head_d;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_d + ptr_t'(i);
      if (!scan_hit && ent_d[scan_idx].alloc && !ent_d[scan_idx].filled) begin
        fill_d   = scan_idx;
        scan_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
      drop_q <= '0;
    end else begin
      ent_q  <= ent_d;
      head_q <= head_d;
      tail_q <= tail_d;
      fill_q <= fill_d;
      drop_q <= drop_d;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: per-cycle queue/memory reference model
// plus directed scenarios and a randomized soak.
module tb_instruction_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_queue_if ifc();
  instruction_fetch_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .io(ifc));

  typedef struct { logic [31:0] pc; logic [31:0] data; bit mis; bit done; } ent_t;
  typedef struct { int due; logic [31:0] data; bit stale; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; bit mis; int cyc; } obs_t;

  ent_t        ref_q[$];
  mreq_t       mem_q[$];
  obs_t        out_q[$];
  logic [31:0] src_q[$];
  int          lat_q[$];
  int total = 0, bad = 0, cyc = 0, serial = 0, last_due = 0;
  int dut_acc = 0, dut_req = 0;
  int req_pct = 100, rdy_pct = 100, pcv_pct = 100, flush_pct = 0, lat_def = 1;
  bit lat_rand = 0;

  // One clock of checking and modelling, then drive the next cycle's inputs.
  task automatic tick();
    bit mis, space, exp_pr, exp_rv, ev, exp_busy, acc, hit;
    int lat;
    ent_t e;
    mreq_t m;
    obs_t o;
    @(negedge clk);
    mis      = ifc.pc_in[1:0] != 2'b00;
    space    = (ref_q.size() < DEPTH) && (mem_q.size() < DEPTH);
    exp_pr   = space && !ifc.flush && (mis || ifc.imem_req_ready);
    exp_rv   = ifc.pc_valid && !mis && space && !ifc.flush;
    ev       = ref_q.size() != 0 && ref_q[0].done;
    exp_busy = ref_q.size() != 0 || mem_q.size() != 0;
    total++; if (ifc.pc_ready !== exp_pr) begin bad++;
      $display("FAIL pc_ready cyc=%0d got=%b exp=%b", cyc, ifc.pc_ready, exp_pr); end
    total++; if (ifc.imem_req_valid !== exp_rv) begin bad++;
      $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, ifc.imem_req_valid, exp_rv); end
    if (exp_rv) begin total++; if (ifc.imem_req_addr !== ifc.pc_in) begin bad++;
      $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, ifc.imem_req_addr, ifc.pc_in); end end
    total++; if (ifc.instr_valid !== ev) begin bad++;
      $display("FAIL instr_valid cyc=%0d got=%b exp=%b", cyc, ifc.instr_valid, ev); end
    if (ev) begin
      total++; if (ifc.instr_pc !== ref_q[0].pc || ifc.instr_data !== ref_q[0].data ||
                   ifc.instr_misaligned !== ref_q[0].mis) begin bad++;
        $display("FAIL instr_fields cyc=%0d got=%h/%h/%b exp=%h/%h/%b", cyc, ifc.instr_pc,
                 ifc.instr_data, ifc.instr_misaligned, ref_q[0].pc, ref_q[0].data, ref_q[0].mis); end
    end
    total++; if (ifc.busy !== exp_busy) begin bad++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, ifc.busy, exp_busy); end

    if (ifc.pc_valid && ifc.pc_ready) dut_acc++;
    if (ifc.imem_req_valid && ifc.imem_req_ready) dut_req++;
    if (ifc.instr_valid && ifc.instr_ready && !ifc.flush) begin
      o.pc = ifc.instr_pc; o.data = ifc.instr_data; o.mis = ifc.instr_misaligned; o.cyc = cyc;
      out_q.push_back(o);
    end

    // Model: a flush orphans every outstanding read; responses come back in order.
    if (ifc.flush) begin
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      ref_q.delete();
    end
    if (ifc.imem_resp_valid) begin
      total++;
      if (mem_q.size() == 0) begin bad++;
        $display("FAIL protocol cyc=%0d response with nothing outstanding", cyc);
      end else begin
        m = mem_q.pop_front();
        hit = 0;
        if (!m.stale)
          foreach (ref_q[i])
            if (!hit && !ref_q[i].done) begin ref_q[i].done = 1; ref_q[i].data = m.data; hit = 1; end
      end
    end
    if (!ifc.flush) begin
      if (ev && ifc.instr_ready) void'(ref_q.pop_front());
      acc = ifc.pc_valid && exp_pr;
      if (acc) begin
        e.pc = ifc.pc_in; e.mis = mis; e.done = mis; e.data = '0;
        ref_q.push_back(e);
        if (src_q.size() != 0) void'(src_q.pop_front());
        if (!mis) begin
          lat = lat_q.size() != 0 ? lat_q.pop_front() :
                (lat_rand ? int'($urandom_range(1, 5)) : lat_def);
          m.due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
          m.data = BASE + 32'(serial); m.stale = 0;
          serial++; last_due = m.due;
          mem_q.push_back(m);
        end
      end
    end

    @(posedge clk); #1;
    cyc++;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      ifc.imem_resp_valid = 1'b1; ifc.imem_resp_data = mem_q[0].data;
    end else begin
      ifc.imem_resp_valid = 1'b0; ifc.imem_resp_data = $urandom;
    end
    ifc.imem_req_ready = $urandom_range(99) < req_pct;
    ifc.instr_ready    = $urandom_range(99) < rdy_pct;
    if (flush_pct != 0) ifc.flush = $urandom_range(99) < flush_pct;
    ifc.pc_valid = src_q.size() != 0 && $urandom_range(99) < pcv_pct;
    ifc.pc_in    = src_q.size() != 0 ? src_q[0] : $urandom;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cfg(input int rq, input int rd, input int pv);
    req_pct = rq; rdy_pct = rd; pcv_pct = pv;
    ifc.imem_req_ready = rq >= 100;
    ifc.instr_ready    = rd >= 100;
    ifc.pc_valid       = src_q.size() != 0 && pv >= 100;
    if (src_q.size() != 0) ifc.pc_in = src_q[0];
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((src_q.size() != 0 || ref_q.size() != 0 || mem_q.size() != 0) && n < budget) begin
      tick(); n++;
    end
    total++;
    if (n >= budget) begin bad++; $display("FAIL drain_timeout cyc=%0d budget=%0d", cyc, budget); end
  endtask

  task automatic test_reset();
    ifc.pc_in = '0; ifc.pc_valid = 0; ifc.imem_req_ready = 0; ifc.imem_resp_valid = 0;
    ifc.imem_resp_data = '0; ifc.instr_ready = 0; ifc.flush = 0;
    rst_n = 1'b0;
    #23;
    total++; if (ifc.instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid got=%b exp=0", ifc.instr_valid); end
    total++; if (ifc.instr_data !== 32'h0) begin bad++; $display("FAIL reset_instr_data got=%h exp=0", ifc.instr_data); end
    total++; if (ifc.instr_pc !== 32'h0) begin bad++; $display("FAIL reset_instr_pc got=%h exp=0", ifc.instr_pc); end
    total++; if (ifc.instr_misaligned !== 1'b0) begin bad++; $display("FAIL reset_mis got=%b exp=0", ifc.instr_misaligned); end
    total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", ifc.busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(2);
  endtask

  task automatic test_streaming();
    int t0;
    out_q.delete(); serial = 0;
    for (int k = 0; k < 4; k++) src_q.push_back(32'(4 * k));
    cfg(100, 100, 100);
    t0 = cyc;
    drain(40);
    total++; if (out_q.size() != 4) begin bad++; $display("FAIL stream_count got=%0d exp=4", out_q.size()); end
    foreach (out_q[k]) begin
      total++;
      if (out_q[k].pc !== 32'(4 * k) || out_q[k].data !== BASE + 32'(k) || out_q[k].cyc != t0 + 2 + k) begin
        bad++;
        $display("FAIL stream_out k=%0d got=%h/%h@%0d exp=%h/%h@%0d", k, out_q[k].pc,
                 out_q[k].data, out_q[k].cyc, 32'(4 * k), BASE + 32'(k), t0 + 2 + k);
      end
    end
    total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL stream_busy got=%b exp=0", ifc.busy); end
  endtask

  task automatic test_backpressure();
    int a0;
    out_q.delete(); serial = 0;
    for (int k = 0; k < 6; k++) src_q.push_back(32'(4 * k));
    cfg(100, 0, 100);
    a0 = dut_acc;
    run(8);
    total++; if (dut_acc - a0 != 4) begin bad++; $display("FAIL bp_accepts got=%0d exp=4", dut_acc - a0); end
    total++; if (ifc.pc_ready !== 1'b0) begin bad++; $display("FAIL bp_pc_ready got=%b exp=0", ifc.pc_ready); end
    cfg(100, 100, 100);
    drain(40);
    total++; if (out_q.size() != 6) begin bad++; $display("FAIL bp_count got=%0d exp=6", out_q.size()); end
    foreach (out_q[k]) begin
      total++; if (out_q[k].pc !== 32'(4 * k)) begin bad++;
        $display("FAIL bp_order k=%0d got=%h exp=%h", k, out_q[k].pc, 32'(4 * k)); end
    end
  endtask

  task automatic test_variable_latency();
    out_q.delete(); serial = 0;
    lat_q = '{3, 1, 5};
    src_q = '{32'h200, 32'h204, 32'h208};
    cfg(100, 100, 100);
    drain(40);
    total++; if (out_q.size() != 3) begin bad++; $display("FAIL varlat_count got=%0d exp=3", out_q.size()); end
    foreach (out_q[k]) begin
      total++; if (out_q[k].pc !== 32'h200 + 32'(4 * k) || out_q[k].data !== BASE + 32'(k)) begin bad++;
        $display("FAIL varlat_out k=%0d got=%h/%h exp=%h/%h", k, out_q[k].pc, out_q[k].data,
                 32'h200 + 32'(4 * k), BASE + 32'(k)); end
    end
  endtask

  task automatic test_misaligned();
    int r0;
    out_q.delete(); serial = 0;
    src_q = '{32'h4, 32'h6, 32'h8};
    cfg(100, 100, 100);
    r0 = dut_req;
    drain(40);
    total++; if (dut_req - r0 != 2) begin bad++; $display("FAIL mis_requests got=%0d exp=2", dut_req - r0); end
    total++; if (out_q.size() != 3) begin bad++; $display("FAIL mis_count got=%0d exp=3", out_q.size()); end
    else begin
      total++; if (out_q[0].pc !== 32'h4 || out_q[0].data !== BASE || out_q[0].mis !== 1'b0) begin bad++;
        $display("FAIL mis_out0 got=%h/%h/%b exp=4/%h/0", out_q[0].pc, out_q[0].data, out_q[0].mis, BASE); end
      total++; if (out_q[1].pc !== 32'h6 || out_q[1].data !== 32'h0 || out_q[1].mis !== 1'b1) begin bad++;
        $display("FAIL mis_out1 got=%h/%h/%b exp=6/0/1", out_q[1].pc, out_q[1].data, out_q[1].mis); end
      total++; if (out_q[2].pc !== 32'h8 || out_q[2].data !== BASE + 32'h1 || out_q[2].mis !== 1'b0) begin bad++;
        $display("FAIL mis_out2 got=%h/%h/%b exp=8/%h/0", out_q[2].pc, out_q[2].data, out_q[2].mis, BASE + 32'h1); end
    end
  endtask

  task automatic test_flush();
    int a0;
    out_q.delete(); serial = 0;
    lat_q = '{8, 8, 8};
    src_q = '{32'h0, 32'h4, 32'h8};
    cfg(100, 100, 100);
    a0 = dut_acc;
    run(3);
    total++; if (dut_acc - a0 != 3) begin bad++; $display("FAIL flush_accepts got=%0d exp=3", dut_acc - a0); end
    ifc.flush = 1'b1;
    tick();
    ifc.flush = 1'b0;
    total++; if (ifc.instr_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", ifc.instr_valid); end
    total++; if (ifc.busy !== 1'b1) begin bad++; $display("FAIL flush_busy got=%b exp=1", ifc.busy); end
    src_q = '{32'h100, 32'h104};
    cfg(100, 100, 100);
    drain(60);
    total++; if (out_q.size() != 2) begin bad++; $display("FAIL flush_count got=%0d exp=2", out_q.size()); end
    else begin
      total++; if (out_q[0].pc !== 32'h100 || out_q[0].data !== BASE + 32'h3) begin bad++;
        $display("FAIL flush_new0 got=%h/%h exp=100/%h", out_q[0].pc, out_q[0].data, BASE + 32'h3); end
      total++; if (out_q[1].pc !== 32'h104 || out_q[1].data !== BASE + 32'h4) begin bad++;
        $display("FAIL flush_new1 got=%h/%h exp=104/%h", out_q[1].pc, out_q[1].data, BASE + 32'h4); end
    end
  endtask

  task automatic test_flush_resp_reset();
    bit hit = 0;
    out_q.delete(); serial = 0;
    lat_q = '{3, 6, 6};
    src_q = '{32'h300, 32'h304, 32'h308};
    cfg(100, 100, 100);
    for (int i = 0; i < 12 && !hit; i++) begin tick(); hit = ifc.imem_resp_valid; end
    total++; if (!hit) begin bad++; $display("FAIL frr_wait_resp got=0 exp=1"); end
    ifc.flush = 1'b1;
    tick();
    ifc.flush = 1'b0;
    total++; if (ifc.busy !== 1'b1) begin bad++; $display("FAIL frr_busy got=%b exp=1", ifc.busy); end
    src_q = '{32'h400, 32'h404, 32'h408, 32'h40c};
    cfg(100, 100, 100);
    run(4);
    #2 rst_n = 1'b0;
    #1;
    total++; if (ifc.instr_valid !== 1'b0 || ifc.instr_data !== 32'h0 || ifc.instr_pc !== 32'h0 ||
                 ifc.instr_misaligned !== 1'b0 || ifc.busy !== 1'b0) begin bad++;
      $display("FAIL async_reset got=%b/%h/%h/%b/%b exp=0/0/0/0/0", ifc.instr_valid, ifc.instr_data,
               ifc.instr_pc, ifc.instr_misaligned, ifc.busy); end
    ref_q.delete(); mem_q.delete(); src_q.delete(); lat_q.delete();
    last_due = 0;
    ifc.imem_resp_valid = 1'b0; ifc.pc_valid = 1'b0; ifc.flush = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    run(3);
  endtask

  task automatic test_random();
    logic [31:0] p;
    cfg(75, 70, 80);
    flush_pct = 3; lat_rand = 1;
    for (int i = 0; i < 1500; i++) begin
      if (src_q.size() < 3) begin
        p = 32'($urandom_range(0, 4095)) << 2;
        if ($urandom_range(99) < 20) p[1:0] = 2'($urandom_range(1, 3));
        src_q.push_back(p);
      end
      tick();
    end
    flush_pct = 0; lat_rand = 0; ifc.flush = 1'b0;
    cfg(100, 100, 100);
    drain(200);
    total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL random_idle_busy got=%b exp=0", ifc.busy); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_variable_latency();
    test_misaligned();
    test_flush();
    test_flush_resp_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
